// File: rtl/dense_feed_pkg.sv
// Shared types and constants for the dense-datapath feeder and its accumulator.
package dense_feed_pkg;

    localparam int DENSE_TAPS  = 9;
    localparam int DENSE_ACC_W = 32;

    typedef logic signed [DENSE_ACC_W-1:0] dense_acc_t;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD,
        PAD,
        FIRE,
        WAIT,
        ACC,
        OUT
    } dense_feed_state_t;

endpackage

// File: rtl/dense_feeder_acc.sv
// Wrapping signed accumulator for MAC partial sums, with a held result register
// presented over a valid/ready handshake.
module dense_acc
    import dense_feed_pkg::*;
#(
    parameter int DW    = 16,
    parameter int ACC_W = $bits(dense_acc_t)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    acc_en,
    input  logic                    last,
    input  logic signed [DW-1:0]    partial,
    input  logic                    res_ready,
    output logic                    res_valid,
    output logic signed [ACC_W-1:0] res_data
);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum;

    // The sized cast of a signed operand sign-extends the partial sum.
    assign sum = acc + ACC_W'(partial);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            if (clr) begin
                acc <= '0;
            end else if (acc_en) begin
                acc <= sum;
            end

            if (acc_en && last) begin
                res_data  <= sum;
                res_valid <= 1'b1;
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/dense_feeder.sv
// Sequencer feeding the 9-tap dense datapath: chunks each neuron's vector into
// groups of 9, fires the MAC per group and accumulates one result per neuron.
module dense_feeder
    import dense_feed_pkg::*;
#(
    parameter int DW      = 16,
    parameter int FW      = 16,
    parameter int LEN_W   = 16,
    parameter int ACC_W   = $bits(dense_acc_t),
    parameter int MAC_LAT = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        vec_len,
    input  logic [LEN_W-1:0]        num_out,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DW-1:0]           in_act,
    input  logic [FW-1:0]           in_wt,
    output logic                    shifting_line,
    output logic                    shifting_filter,
    output logic                    line_buffer_reset,
    output logic [DW-1:0]           input_line,
    output logic [FW-1:0]           input_filter,
    output logic [7:0]              dense_valid,
    output logic                    mac_enable,
    input  logic signed [DW-1:0]    dense_data,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [ACC_W-1:0] res_data,
    output logic                    busy,
    output logic                    done
);

    localparam logic [3:0] TAPS      = 4'(DENSE_TAPS);
    localparam int         WAIT_LAST = (MAC_LAT >= 2) ? MAC_LAT - 2 : 0;

    dense_feed_state_t state;
    dense_feed_state_t next_state;

    logic [3:0]       k;
    logic [3:0]       k_inc;
    logic [LEN_W-1:0] e;
    logic [LEN_W-1:0] e_inc;
    logic [LEN_W-1:0] vec_len_q;
    logic [LEN_W-1:0] num_out_q;
    logic [LEN_W-1:0] n_done;
    logic [15:0]      wait_cnt;

    logic accept;
    logic bad_start;
    logic last_chunk;
    logic last_neuron;
    logic acc_clr;
    logic acc_en;
    logic mac_enable_d;
    logic lbr_d;
    logic busy_d;
    logic done_d;

    assign k_inc       = k + 4'd1;
    assign e_inc       = e + LEN_W'(1);
    assign accept      = in_valid && in_ready;
    assign bad_start   = (vec_len == '0) || (num_out == '0);
    assign last_chunk  = (e == vec_len_q);
    assign last_neuron = (n_done == num_out_q - LEN_W'(1));
    assign acc_clr     = (state == CLR);
    assign acc_en      = (state == ACC);

    // State, counters and all registered outputs; k doubles as the pad counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            k                 <= '0;
            e                 <= '0;
            vec_len_q         <= '0;
            num_out_q         <= '0;
            n_done            <= '0;
            wait_cnt          <= '0;
            dense_valid       <= '0;
            mac_enable        <= 1'b0;
            line_buffer_reset <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
        end else begin
            state             <= next_state;
            mac_enable        <= mac_enable_d;
            line_buffer_reset <= lbr_d;
            busy              <= busy_d;
            done              <= done_d;
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_len_q <= vec_len;
                        num_out_q <= num_out;
                        n_done    <= '0;
                    end
                end
                CLR: begin
                    k <= '0;
                    e <= '0;
                end
                LOAD: begin
                    if (accept) begin
                        k <= k_inc;
                        e <= e_inc;
                        if (next_state != LOAD) begin
                            dense_valid <= 8'(k_inc);
                        end
                    end
                end
                PAD:  k        <= k_inc;
                FIRE: wait_cnt <= '0;
                WAIT: wait_cnt <= wait_cnt + 16'd1;
                ACC:  k        <= '0;
                OUT: begin
                    if (res_ready && !last_neuron) begin
                        n_done <= n_done + LEN_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start && !bad_start) next_state = CLR;
            CLR:  next_state = LOAD;
            LOAD: begin
                if (accept) begin
                    if (k_inc == TAPS) begin
                        next_state = FIRE;
                    end else if (e_inc == vec_len_q) begin
                        next_state = PAD;
                    end
                end
            end
            PAD:  if (k_inc == TAPS) next_state = FIRE;
            FIRE: next_state = (MAC_LAT > 1) ? WAIT : ACC;
            WAIT: if (wait_cnt == 16'(WAIT_LAST)) next_state = ACC;
            ACC:  next_state = last_chunk ? OUT : LOAD;
            OUT:  if (res_ready) next_state = last_neuron ? IDLE : CLR;
            default: next_state = IDLE;
        endcase
    end

    // Shift strobes and data follow the handshake directly; the rest are next-cycle values.
    always_comb begin
        in_ready      = 1'b0;
        shifting_line = 1'b0;
        input_line    = '0;
        input_filter  = '0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    shifting_line = 1'b1;
                    input_line    = in_act;
                    input_filter  = in_wt;
                end
            end
            PAD: shifting_line = 1'b1;
            default: ;
        endcase
        mac_enable_d = (next_state == FIRE);
        lbr_d        = (next_state == CLR);
        busy_d       = (next_state != IDLE);
        done_d       = (state == IDLE && start && bad_start) ||
                       (state == OUT && res_ready && last_neuron);
    end

    assign shifting_filter = shifting_line;

    dense_acc #(
        .DW    (DW),
        .ACC_W (ACC_W)
    ) u_acc (
        .clk       (clk),
        .rst       (rst),
        .clr       (acc_clr),
        .acc_en    (acc_en),
        .last      (last_chunk),
        .partial   (dense_data),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_data  (res_data)
    );

endmodule

// File: tb/tb_dense_feeder.sv
// Bench for dense_feeder: a mock shift-buffer/MAC datapath answers the DUT, and
// results are compared against a chunked dot-product model of each neuron.
module tb_dense_feeder;

    localparam int DW      = 12;
    localparam int FW      = 8;
    localparam int LEN_W   = 16;
    localparam int ACC_W   = 16;
    localparam int MAC_LAT = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] vec_len;
    logic [LEN_W-1:0] num_out;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    in_act;
    logic [FW-1:0]    in_wt;
    logic             shifting_line;
    logic             shifting_filter;
    logic             line_buffer_reset;
    logic [DW-1:0]    input_line;
    logic [FW-1:0]    input_filter;
    logic [7:0]       dense_valid;
    logic             mac_enable;
    logic [DW-1:0]    dense_data;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             busy;
    logic             done;

    dense_feeder #(
        .DW(DW), .FW(FW), .LEN_W(LEN_W), .ACC_W(ACC_W), .MAC_LAT(MAC_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .vec_len(vec_len), .num_out(num_out),
        .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wt(in_wt),
        .shifting_line(shifting_line), .shifting_filter(shifting_filter),
        .line_buffer_reset(line_buffer_reset), .input_line(input_line),
        .input_filter(input_filter), .dense_valid(dense_valid), .mac_enable(mac_enable),
        .dense_data(dense_data), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Mock datapath state and event counters
    logic signed [DW-1:0] line_taps [9];
    logic signed [FW-1:0] filt_taps [9];
    logic [DW-1:0]        pipe0;
    logic [DW-1:0]        pipe1;
    logic                 stall_seen = 1'b0;
    logic [ACC_W-1:0]     stall_val;
    int shift_cnt = 0, pad_cnt = 0, mac_cnt = 0, lbr_cnt = 0, done_cnt = 0, viol_cnt = 0;
    logic [7:0]       dv_q [$];
    logic [ACC_W-1:0] res_q [$];

    int act_a [];
    int wt_a [];
    int exp_q [$];
    int res_base, dv_base, shift_base, pad_base, mac_base, lbr_base, done_base, viol_base;
    int hs_at_done;

    assign dense_data = pipe1;

    function automatic logic [DW-1:0] tapDot();
        int s = 0;
        for (int i = 0; i < 9; i++) s += int'(line_taps[i]) * int'(filt_taps[i]);
        return DW'(s);
    endfunction

    // Result is only valid in the cycle exactly MAC_LAT after the fire strobe.
    always @(posedge clk) begin
        if (line_buffer_reset) begin
            for (int i = 0; i < 9; i++) begin
                line_taps[i] <= '0;
                filt_taps[i] <= '0;
            end
            lbr_cnt <= lbr_cnt + 1;
        end
        if (shifting_line) begin
            for (int i = 0; i < 8; i++) begin
                line_taps[i] <= line_taps[i+1];
                filt_taps[i] <= filt_taps[i+1];
            end
            line_taps[8] <= input_line;
            filt_taps[8] <= input_filter;
            shift_cnt <= shift_cnt + 1;
            if (!in_ready) begin
                pad_cnt <= pad_cnt + 1;
                if (input_line != '0 || input_filter != '0) viol_cnt <= viol_cnt + 1;
            end else if (!in_valid || input_line != in_act || input_filter != in_wt) begin
                viol_cnt <= viol_cnt + 1;
            end
        end
        if (shifting_line != shifting_filter) viol_cnt <= viol_cnt + 1;
        if (mac_enable) begin
            mac_cnt <= mac_cnt + 1;
            dv_q.push_back(dense_valid);
            pipe0 <= tapDot();
        end else begin
            pipe0 <= 12'hA5A;
        end
        pipe1 <= pipe0;
        if (res_valid && !res_ready) begin
            stall_seen <= 1'b1;
            stall_val  <= res_data;
        end else begin
            stall_seen <= 1'b0;
        end
        if (stall_seen && res_data != stall_val) viol_cnt <= viol_cnt + 1;
        if (res_valid && res_ready) res_q.push_back(res_data);
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] getDv(int i);
        if (i < dv_q.size()) return 32'(dv_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] getRes(int i);
        if (i < res_q.size()) return 32'(res_q[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic void fillRandom(int vl, int no);
        act_a = new[vl];
        wt_a  = new[vl * no];
        foreach (act_a[i]) act_a[i] = int'($urandom_range(0, 4095)) - 2048;
        foreach (wt_a[i])  wt_a[i]  = int'($urandom_range(0, 255)) - 128;
    endfunction

    // Reference: per-neuron dot product in chunks of 9, each chunk truncated to a
    // signed DW-bit partial, partials summed modulo 2^ACC_W.
    function automatic void buildExpected(int vl, int no);
        int acc, p;
        exp_q.delete();
        for (int n = 0; n < no; n++) begin
            acc = 0;
            for (int c = 0; c < vl; c += 9) begin
                p = 0;
                for (int j = c; j < c + 9 && j < vl; j++) p += act_a[j] * wt_a[n * vl + j];
                p = p & 32'hFFF;
                if (p > 2047) p -= 4096;
                acc = (acc + p) & 32'hFFFF;
            end
            exp_q.push_back(acc);
        end
    endfunction

    task automatic applyStimulus(input int vl, input int no, input bit toggle,
                                 input int stall, input string tag);
        int idx, cyc, total, stall_left, hs_cnt;
        bit got_done, acc_now, hs, stalled;
        buildExpected(vl, no);
        res_base = res_q.size();  dv_base  = dv_q.size();
        shift_base = shift_cnt;   pad_base = pad_cnt;   mac_base = mac_cnt;
        lbr_base = lbr_cnt;       done_base = done_cnt; viol_base = viol_cnt;
        hs_at_done = -1;
        total = vl * no; idx = 0; cyc = 0; stall_left = stall; hs_cnt = 0; got_done = 0;
        @(negedge clk);
        start = 1'b1; vec_len = LEN_W'(vl); num_out = LEN_W'(no);
        @(negedge clk);
        start = 1'b0;
        while (!got_done && cyc < 4000) begin
            in_valid  = (idx < total) && (!toggle || cyc[0]);
            in_act    = (idx < total) ? DW'(act_a[idx % vl]) : '0;
            in_wt     = (idx < total) ? FW'(wt_a[idx]) : '0;
            res_ready = res_valid && (stall_left == 0);
            #1;
            acc_now = in_valid && in_ready;
            hs      = res_valid && res_ready;
            stalled = res_valid && !res_ready;
            if (done) begin
                got_done   = 1'b1;
                hs_at_done = hs_cnt;
            end
            @(negedge clk);
            cyc++;
            if (acc_now) idx++;
            if (hs) begin
                hs_cnt++;
                stall_left = stall;
            end else if (stalled && stall_left > 0) begin
                stall_left--;
            end
        end
        in_valid = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, "_done"}, 32'(got_done), 1);
        checkOutput({tag, "_nres"}, res_q.size() - res_base, no);
        for (int i = 0; i < no; i++) checkOutput({tag, "_res"}, getRes(res_base + i), 32'(exp_q[i]));
        checkOutput({tag, "_viol"}, viol_cnt - viol_base, 0);
    endtask

    int cyc_wait;
    int vl_r, no_r;

    initial begin
        rst = 1'b0; start = 1'b0; vec_len = '0; num_out = '0;
        in_valid = 1'b0; in_act = '0; in_wt = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", {busy, done, res_valid, mac_enable, in_ready, shifting_line,
                                   shifting_filter, line_buffer_reset}, 0);
        checkOutput("reset_dv", dense_valid, 0);
        checkOutput("reset_res", res_data, 0);
        rst = 1'b1;
        @(negedge clk);

        // Single full chunk: 1..9 against unit weights
        act_a = new[9]; wt_a = new[9];
        foreach (act_a[i]) begin act_a[i] = i + 1; wt_a[i] = 1; end
        applyStimulus(9, 1, 1'b0, 0, "full");
        checkOutput("full_45", getRes(res_base), 45);
        checkOutput("full_shifts", shift_cnt - shift_base, 9);
        checkOutput("full_mac", mac_cnt - mac_base, 1);
        checkOutput("full_dv", getDv(dv_base), 9);
        checkOutput("full_lbr", lbr_cnt - lbr_base, 1);
        checkOutput("full_done", done_cnt - done_base, 1);

        // Partial trailing chunk
        fillRandom(13, 1);
        applyStimulus(13, 1, 1'b0, 0, "part");
        checkOutput("part_mac", mac_cnt - mac_base, 2);
        checkOutput("part_dv0", getDv(dv_base), 9);
        checkOutput("part_dv1", getDv(dv_base + 1), 4);
        checkOutput("part_pad", pad_cnt - pad_base, 5);

        // Wrap: sixteen partials of 0x7FF then 0x10 reach exactly 0x8000
        act_a = new[153]; wt_a = new[153];
        foreach (act_a[i]) begin
            act_a[i] = (i % 9 == 0) ? ((i == 144) ? 16 : 2047) : 0;
            wt_a[i]  = (i % 9 == 0) ? 1 : 0;
        end
        applyStimulus(153, 1, 1'b0, 0, "wrap");
        checkOutput("wrap_8000", getRes(res_base), 32'h8000);

        // Negative partial must sign-extend
        act_a = new[9]; wt_a = new[9];
        foreach (act_a[i]) begin act_a[i] = (i == 0) ? -3 : 0; wt_a[i] = 1; end
        applyStimulus(9, 1, 1'b0, 0, "neg");
        checkOutput("neg_fffd", getRes(res_base), 32'hFFFD);

        // Backpressure on both sides
        fillRandom(20, 2);
        applyStimulus(20, 2, 1'b1, 5, "bp");
        checkOutput("bp_shifts", shift_cnt - shift_base, 54);

        // Multiple neurons
        fillRandom(9, 3);
        applyStimulus(9, 3, 1'b0, 0, "multi");
        checkOutput("multi_lbr", lbr_cnt - lbr_base, 3);
        checkOutput("multi_done", done_cnt - done_base, 1);
        checkOutput("multi_done_after_3", 32'(hs_at_done), 3);

        // Reset asserted while waiting on the MAC
        @(negedge clk);
        start = 1'b1; vec_len = 16'd9; num_out = 16'd1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_act = 12'd5; in_wt = 8'd3;
        cyc_wait = 0;
        while (!mac_enable && cyc_wait < 50) begin
            @(negedge clk);
            cyc_wait++;
        end
        checkOutput("rst_fire_seen", 32'(mac_enable), 1);
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_pre_busy", 32'(busy), 1);
        rst = 1'b0;
        #1;
        checkOutput("rst_ctrl", {busy, done, res_valid, mac_enable, in_ready, shifting_line,
                                 shifting_filter, line_buffer_reset}, 0);
        checkOutput("rst_dv", dense_valid, 0);
        checkOutput("rst_res", res_data, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_resvalid_after", 32'(res_valid), 0);
        fillRandom(11, 1);
        applyStimulus(11, 1, 1'b0, 0, "postrst");

        // Degenerate starts
        shift_base = shift_cnt;
        @(negedge clk);
        start = 1'b1; vec_len = 16'd0; num_out = 16'd2;
        @(negedge clk);
        start = 1'b0;
        checkOutput("degen_vl_done", 32'(done), 1);
        checkOutput("degen_vl_busy", 32'(busy), 0);
        start = 1'b1; vec_len = 16'd5; num_out = 16'd0;
        @(negedge clk);
        start = 1'b0;
        checkOutput("degen_no_done", 32'(done), 1);
        repeat (3) @(negedge clk);
        checkOutput("degen_shift", shift_cnt - shift_base, 0);
        checkOutput("degen_busy_after", 32'(busy), 0);

        // Randomised jobs
        for (int r = 0; r < 4; r++) begin
            vl_r = int'($urandom_range(1, 30));
            no_r = int'($urandom_range(1, 3));
            fillRandom(vl_r, no_r);
            applyStimulus(vl_r, no_r, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dense_feeder.md
# dense_feeder

Sequencer and accumulator that drives the 9-tap dense datapath (line/filter shift buffers plus 9-input MAC) from streamed activation/weight pairs. For each output neuron it chunks a vector of `vec_len` pairs into groups of 9, shifts each group into the datapath, fires the MAC and accumulates the partial sums. It then emits one accumulated result per neuron over a valid/ready handshake. It sits between the pool_nl input FIFOs and the dense datapath, on the initiator side of its shift/enable interface.

## Interface
- `DW`, `` `WID_PE_BITS ``: activation width, and the width of MAC output `dense_data`.
- `FW`, `` `WID_FILTER ``: weight width.
- `LEN_W`, 16: width of `vec_len` and `num_out`.
- `ACC_W`, 32: accumulator and result width.
- `MAC_LAT`, 2: cycles from the `mac_enable` cycle to a valid `dense_data`. Legal range ≥1.
- `clk`, input, 1: clock, rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: one-cycle pulse that launches a job. Ignored unless in IDLE.
- `vec_len`, input, LEN_W: pairs per neuron. Sampled on `start`.
- `num_out`, input, LEN_W: neurons per job. Sampled on `start`.
- `in_valid`, input, 1: activation/weight pair valid.
- `in_ready`, output, 1: pair accepted when `in_valid && in_ready`.
- `in_act`, input, DW: activation.
- `in_wt`, input, FW: weight.
- `shifting_line`, output, 1: shift strobe to the line buffer.
- `shifting_filter`, output, 1: shift strobe to the filter buffer. Always identical to `shifting_line`.
- `line_buffer_reset`, output, 1: one-cycle clear of the line buffer.
- `input_line`, output, DW: data shifted into the line buffer.
- `input_filter`, output, FW: data shifted into the filter buffer.
- `dense_valid`, output, 8: count of valid taps, 1..9.
- `mac_enable`, output, 1: MAC fire strobe.
- `dense_data`, input, DW (signed): MAC partial sum.
- `res_valid`, output, 1: result valid.
- `res_ready`, input, 1: result accepted when `res_valid && res_ready`.
- `res_data`, output, ACC_W (signed): accumulated neuron result.
- `busy`, output, 1: high whenever the FSM is not in IDLE.
- `done`, output, 1: one-cycle pulse when the job completes.

## Operation
- FSM states: IDLE, CLR, LOAD, PAD, FIRE, WAIT, ACC, OUT.
- IDLE → CLR on `start` when `vec_len != 0 && num_out != 0`.
- `start` with `vec_len == 0` or `num_out == 0`: no state change, `done` pulses the next cycle.
- CLR (1 cycle): `line_buffer_reset=1`, accumulator ← 0, tap count k ← 0, element count e ← 0. Next state LOAD.
- LOAD: `in_ready=1`.
  - Each accepted pair: `shifting_*=1` the same cycle, `input_line=in_act`, `input_filter=in_wt`, k++, e++.
  - Exit when k==9 (to FIRE) or e==vec_len (to PAD if k<9, else FIRE).
  - `in_ready` drops combinationally on the exit cycle, so no pair is accepted beyond the chunk.
- PAD: shifts zeros (`input_line=0`, `input_filter=0`) for 9−k cycles, so the valid data ends in taps 1..k. Then FIRE.
- `dense_valid` = 9 for full chunks and k for the final partial chunk. It is held stable from FIRE through ACC.
- FIRE (1 cycle): `mac_enable=1`. Next state WAIT.
- WAIT: MAC_LAT−1 cycles (0 cycles when MAC_LAT=1). Then ACC.
- ACC (1 cycle): acc ← acc + sign-extended `dense_data`, wrapping modulo 2^ACC_W. k ← 0.
  - If e < vec_len: next state LOAD.
  - Otherwise: `res_data ← acc` (including this cycle's add), next state OUT.
- OUT: `res_valid=1` until `res_ready`.
  - On handshake: if neurons-done < num_out−1, go to CLR for the next neuron (activations are re-streamed by upstream).
  - Otherwise pulse `done` and go to IDLE.
- `res_data` holds its value while `res_valid && !res_ready`.

## Timing
- Reset values: every output is 0, `dense_valid=0`, state IDLE, all counters 0.
- Reset is asynchronous and can be asserted mid-job. Release returns to IDLE with no residual `res_valid`. Line-buffer contents are not cleared by reset; the next CLR clears them.
- All outputs are registered except `in_ready` and the `shifting_*`/`input_*` data, which are a combinational function of the handshake in LOAD.
- Per-chunk latency: A accept cycles (A ≥ k) + (9−k) pad cycles + 1 FIRE + (MAC_LAT−1) WAIT + 1 ACC.
- `res_valid` rises the cycle after the final ACC.
- With `in_valid` held high and MAC_LAT=2, a full chunk takes 12 cycles.
- `start` arriving in the same cycle as the final OUT handshake is ignored.

## Structure
- Shared package `dense_feed_pkg` holds:
  - the state enum `dense_feed_state_t`;
  - the constant `DENSE_TAPS = 9`;
  - the type `dense_acc_t` (logic signed [ACC_W-1:0]).
- One sub-module, `dense_acc`: clear, enable, sign-extending wrap adder and result register, with `res_valid`/`res_ready` holding logic. The FSM and counters stay in `dense_feeder`.

## Test plan
- **Single full chunk.** `vec_len=9`, `num_out=1`, act 1..9, weights all 1, mock MAC returns sum of taps → `res_data=45`, exactly 9 shift strobes, one `mac_enable`, `dense_valid=9`, `done` after the handshake.
- **Partial chunk.** `vec_len=13` → two FIRE cycles. The second chunk shows `dense_valid=4` and 5 zero-pad shifts. `res_data` = sum of both partials.
- **Negative and wrap.** `ACC_W=16`, partials 0x7FFF and 0x0001 → `res_data=0x8000`. A partial of −3 is sign-extended correctly.
- **Backpressure.** `in_valid` toggles every other cycle and `res_ready` is held low 5 cycles → no shift without a handshake, and `res_data` is stable while stalled.
- **Multi-neuron.** `num_out=3`, `vec_len=9` → three results and three `line_buffer_reset` pulses, with `done` only after the third handshake.
- **Reset and degenerate start.** `rst` asserted mid-WAIT → all outputs 0 immediately, and a new job runs clean afterwards. `start` with `vec_len=0` → `done` pulse with no shift.
